// File: rtl/lmem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lmem_pkg
// Description : Shared constants, bank-select codes, depth lookup and FSM
//               state type for the layer-memory responder.
// Revision    : 1.0  initial release
// ============================================================================
package lmem_pkg;

   localparam int DW       = 20;
   localparam int AW       = 12;
   localparam int L0_DEPTH = 4096;
   localparam int L1_DEPTH = 1024;
   localparam int L2_DEPTH = 2048;

   localparam logic [2:0] CSEL_L0K0 = 3'b001;
   localparam logic [2:0] CSEL_L0K1 = 3'b010;
   localparam logic [2:0] CSEL_L1K0 = 3'b011;
   localparam logic [2:0] CSEL_L1K1 = 3'b100;
   localparam logic [2:0] CSEL_L2   = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DUMP  = 2'd2
   } state_t;

   // Depth of the bank behind a select code; 0 marks an invalid code.
   function automatic logic [AW:0] depth_of(input logic [2:0] sel);
      case (sel)
         CSEL_L0K0, CSEL_L0K1: depth_of = (AW+1)'(L0_DEPTH);
         CSEL_L1K0, CSEL_L1K1: depth_of = (AW+1)'(L1_DEPTH);
         CSEL_L2:              depth_of = (AW+1)'(L2_DEPTH);
         default:              depth_of = '0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lm_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lm_bank
// Description : DEPTH x DW storage with one synchronous write port and two
//               asynchronous read ports (initiator side and dump side).
// Revision    : 1.0  initial release
// ============================================================================
module lm_bank #(
   parameter  int DEPTH = 1024,
   parameter  int DW    = 20,
   localparam int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [IW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [IW-1:0] raddr_a_i,
   output logic [DW-1:0] rdata_a_o,
   input  logic [IW-1:0] raddr_b_i,
   output logic [DW-1:0] rdata_b_o
);

   logic [DW-1:0] mem_q [DEPTH];

   // Single write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/layer_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : layer_mem_responder
// Description : Responder for the conv-accelerator layer-memory interface.
//               Five banks selected by csel, a host clear engine and a
//               valid/ready dump streamer.
//               Optional macro LMEM_PROT_CHK_EN adds a sticky protocol
//               error flag (err).
// Revision    : 1.0  initial release
// ============================================================================
module layer_mem_responder #(
   parameter int DW       = lmem_pkg::DW,
   parameter int AW       = lmem_pkg::AW,
   parameter int L0_DEPTH = lmem_pkg::L0_DEPTH,
   parameter int L1_DEPTH = lmem_pkg::L1_DEPTH,
   parameter int L2_DEPTH = lmem_pkg::L2_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    csel,
   input  logic          cwr,
   input  logic [AW-1:0] caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   input  logic          crd,
   input  logic [AW-1:0] caddr_rd,
   output logic [DW-1:0] cdata_rd,
   input  logic          clr_start,
   output logic          clr_busy,
   input  logic          dump_start,
   input  logic [2:0]    dump_sel,
   output logic          dump_valid,
   input  logic          dump_ready,
   output logic [DW-1:0] dump_data,
   output logic [AW-1:0] dump_addr,
   output logic          dump_last
`ifdef LMEM_PROT_CHK_EN
   ,
   output logic          err
`endif
);

   import lmem_pkg::*;

   // Depth lookup tied to this instance's depth parameters; 0 = invalid select.
   function automatic logic [AW:0] sel_depth(input logic [2:0] sel);
      case (sel)
         CSEL_L0K0, CSEL_L0K1: sel_depth = (AW+1)'(L0_DEPTH);
         CSEL_L1K0, CSEL_L1K1: sel_depth = (AW+1)'(L1_DEPTH);
         CSEL_L2:              sel_depth = (AW+1)'(L2_DEPTH);
         default:              sel_depth = '0;
      endcase
   endfunction

   state_t        state_q, state_d;
   logic [AW-1:0] clr_ptr_q, clr_ptr_d;
   logic [2:0]    dump_sel_q, dump_sel_d;
   logic [AW-1:0] dump_addr_q, dump_addr_d;
   logic [DW-1:0] dump_data_q, dump_data_d;
   logic          dump_valid_q, dump_valid_d;

   logic          w_clearing;
   logic [AW:0]   w_cs_depth;
   logic          w_wr_ok;
   logic          w_rd_ok;
   logic [AW-1:0] w_waddr;
   logic [DW-1:0] w_wdata;
   logic [4:0]    w_we;
   logic [DW-1:0] w_rdata_a [5];
   logic [DW-1:0] w_rdata_b [5];
   logic [DW-1:0] w_rd_word;
   logic [2:0]    w_fetch_sel;
   logic [AW-1:0] w_fetch_addr;
   logic [DW-1:0] w_fetch_data;
   logic          w_dump_at_end;

   assign w_clearing = (state_q == CLEAR);
   assign w_cs_depth = sel_depth(csel);
   // An invalid select has depth 0, so the range check also rejects it.
   assign w_wr_ok    = cwr && !w_clearing && ({1'b0, caddr_wr} < w_cs_depth);
   assign w_rd_ok    = crd && !reset && !w_clearing && ({1'b0, caddr_rd} < w_cs_depth);

   // The clear engine owns the shared write port while it runs.
   assign w_waddr = w_clearing ? clr_ptr_q : caddr_wr;
   assign w_wdata = w_clearing ? '0 : cdata_wr;

   // Dump side prefetches word 0 on entry and word addr+1 on each transfer.
   assign w_fetch_sel  = (state_q == DUMP) ? dump_sel_q : dump_sel;
   assign w_fetch_addr = (state_q == DUMP) ? (dump_addr_q + AW'(1)) : '0;

   assign w_dump_at_end = ({1'b0, dump_addr_q} == (sel_depth(dump_sel_q) - (AW+1)'(1)));

   for (genvar gi = 0; gi < 5; gi++) begin : g_bank
      localparam int D  = (gi < 2) ? L0_DEPTH : ((gi < 4) ? L1_DEPTH : L2_DEPTH);
      localparam int IW = $clog2(D);

      assign w_we[gi] = w_clearing ? ({1'b0, clr_ptr_q} < (AW+1)'(D))
                                   : (w_wr_ok && (csel == 3'(gi + 1)));

      lm_bank #(
         .DEPTH (D),
         .DW    (DW)
      ) u_bank (
         .clk       (clk),
         .we_i      (w_we[gi]),
         .waddr_i   (w_waddr[IW-1:0]),
         .wdata_i   (w_wdata),
         .raddr_a_i (caddr_rd[IW-1:0]),
         .rdata_a_o (w_rdata_a[gi]),
         .raddr_b_i (w_fetch_addr[IW-1:0]),
         .rdata_b_o (w_rdata_b[gi])
      );
   end

   // Bank-select muxes for the initiator read and the dump prefetch.
   always_comb begin
      w_rd_word    = '0;
      w_fetch_data = '0;
      case (csel)
         CSEL_L0K0: w_rd_word = w_rdata_a[0];
         CSEL_L0K1: w_rd_word = w_rdata_a[1];
         CSEL_L1K0: w_rd_word = w_rdata_a[2];
         CSEL_L1K1: w_rd_word = w_rdata_a[3];
         CSEL_L2:   w_rd_word = w_rdata_a[4];
         default:   w_rd_word = '0;
      endcase
      case (w_fetch_sel)
         CSEL_L0K0: w_fetch_data = w_rdata_b[0];
         CSEL_L0K1: w_fetch_data = w_rdata_b[1];
         CSEL_L1K0: w_fetch_data = w_rdata_b[2];
         CSEL_L1K1: w_fetch_data = w_rdata_b[3];
         CSEL_L2:   w_fetch_data = w_rdata_b[4];
         default:   w_fetch_data = '0;
      endcase
   end

   assign cdata_rd   = w_rd_ok ? w_rd_word : '0;
   assign clr_busy   = w_clearing;
   assign dump_valid = dump_valid_q;
   assign dump_data  = dump_data_q;
   assign dump_addr  = dump_addr_q;
   assign dump_last  = dump_valid_q && w_dump_at_end;

   // Next-state logic: clear walk, dump entry/handshake, start-pulse arbitration.
   always_comb begin
      state_d      = state_q;
      clr_ptr_d    = clr_ptr_q;
      dump_sel_d   = dump_sel_q;
      dump_addr_d  = dump_addr_q;
      dump_data_d  = dump_data_q;
      dump_valid_d = dump_valid_q;
      case (state_q)
         IDLE: begin
            if (clr_start) begin
               state_d   = CLEAR;
               clr_ptr_d = '0;
            end else if (dump_start && (sel_depth(dump_sel) != '0)) begin
               state_d      = DUMP;
               dump_sel_d   = dump_sel;
               dump_addr_d  = '0;
               dump_data_d  = w_fetch_data;
               dump_valid_d = 1'b1;
            end
         end
         CLEAR: begin
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == '1) begin
               state_d = IDLE;
            end
         end
         DUMP: begin
            if (dump_valid_q && dump_ready) begin
               if (w_dump_at_end) begin
                  dump_valid_d = 1'b0;
                  state_d      = IDLE;
               end else begin
                  dump_addr_d = dump_addr_q + AW'(1);
                  dump_data_d = w_fetch_data;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         clr_ptr_q    <= '0;
         dump_sel_q   <= '0;
         dump_addr_q  <= '0;
         dump_data_q  <= '0;
         dump_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_ptr_q    <= clr_ptr_d;
         dump_sel_q   <= dump_sel_d;
         dump_addr_q  <= dump_addr_d;
         dump_data_q  <= dump_data_d;
         dump_valid_q <= dump_valid_d;
      end
   end

`ifdef LMEM_PROT_CHK_EN
   // The interface carries a single csel, so a write and a read in the same
   // cycle can never name different banks; that case needs no detector.
   logic err_q, err_d;
   logic w_viol;

   assign w_viol = ((cwr || crd) && (w_cs_depth == '0))
                || (cwr && ({1'b0, caddr_wr} >= w_cs_depth))
                || (crd && ({1'b0, caddr_rd} >= w_cs_depth))
                || ((cwr || crd) && w_clearing);

   assign err_d = clr_start ? 1'b0 : (err_q | w_viol);
   assign err   = err_q;

   // Sticky protocol error flag, cleared by reset or a clear request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`endif

endmodule
`default_nettype wire
